// File: rtl/onehot_dec_seq.sv
// Registered one-hot position tracker: load, clear and shift a single set bit,
// with either wrap-around or saturation at the ends plus one-cycle event pulses.
module onehot_dec_seq #(
    parameter int SEL_W = 3,
    parameter int WRAP  = 1,
    localparam int OUT_W = 2**SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] out,
    output logic [SEL_W-1:0] pos,
    output logic             active,
    output logic             wrap,
    output logic             sat
);

    // Command semantics: en is a single-cycle strobe with no back-pressure;
    // every edge with en=1 executes mode, and the result is visible one edge later.
    localparam logic [1:0] MODE_CLEAR = 2'b00;
    localparam logic [1:0] MODE_LOAD  = 2'b01;
    localparam logic [1:0] MODE_UP    = 2'b10;
    localparam logic [1:0] MODE_DOWN  = 2'b11;

    localparam logic [SEL_W-1:0] POS_MAX = {SEL_W{1'b1}};

    logic [SEL_W-1:0] pos_d;
    logic             active_d;
    logic             wrap_d;
    logic             sat_d;
    logic [OUT_W-1:0] out_d;

    always_comb begin
        pos_d    = pos;
        active_d = active;
        wrap_d   = 1'b0;
        sat_d    = 1'b0;
        if (en) begin
            case (mode)
                MODE_CLEAR: begin
                    pos_d    = '0;
                    active_d = 1'b0;
                end
                MODE_LOAD: begin
                    pos_d    = sel;
                    active_d = 1'b1;
                end
                MODE_UP: begin
                    if (active) begin
                        if (pos == POS_MAX) begin
                            if (WRAP != 0) begin
                                pos_d  = '0;
                                wrap_d = 1'b1;
                            end else begin
                                sat_d = 1'b1;
                            end
                        end else begin
                            pos_d = pos + 1'b1;
                        end
                    end
                end
                MODE_DOWN: begin
                    if (active) begin
                        if (pos == '0) begin
                            if (WRAP != 0) begin
                                pos_d  = POS_MAX;
                                wrap_d = 1'b1;
                            end else begin
                                sat_d = 1'b1;
                            end
                        end else begin
                            pos_d = pos - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
        // Decoding from the next pos keeps out consistent with pos/active by construction.
        out_d = '0;
        if (active_d) begin
            out_d[pos_d] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out    <= '0;
            pos    <= '0;
            active <= 1'b0;
            wrap   <= 1'b0;
            sat    <= 1'b0;
        end else begin
            out    <= out_d;
            pos    <= pos_d;
            active <= active_d;
            wrap   <= wrap_d;
            sat    <= sat_d;
        end
    end

endmodule

// File: tb/tb_onehot_dec_seq.sv
// Directed + random bench for onehot_dec_seq across four parameterisations,
// using an index-based reference model feeding per-instance expected queues.
module tb_onehot_dec_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [5:0] sel_v;

    always #5 clk = ~clk;

    logic [7:0]  o3, o3s;
    logic [2:0]  p3, p3s;
    logic        a3, w3, s3, a3s, w3s, s3s;
    logic [1:0]  o1;
    logic [0:0]  p1;
    logic        a1, w1, s1;
    logic [15:0] o4;
    logic [3:0]  p4;
    logic        a4, w4, s4;

    onehot_dec_seq #(.SEL_W(3), .WRAP(1)) u3 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel_v[2:0]),
        .out(o3), .pos(p3), .active(a3), .wrap(w3), .sat(s3));
    onehot_dec_seq #(.SEL_W(3), .WRAP(0)) u3s (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel_v[2:0]),
        .out(o3s), .pos(p3s), .active(a3s), .wrap(w3s), .sat(s3s));
    onehot_dec_seq #(.SEL_W(1), .WRAP(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel_v[0:0]),
        .out(o1), .pos(p1), .active(a1), .wrap(w1), .sat(s1));
    onehot_dec_seq #(.SEL_W(4), .WRAP(1)) u4 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel_v[3:0]),
        .out(o4), .pos(p4), .active(a4), .wrap(w4), .sat(s4));

    // Expected record: {out[15:0], pos[3:0], active, wrap, sat}
    logic [22:0] exp_q3[$], exp_q3s[$], exp_q1[$], exp_q4[$];
    int m_idx[4];  // model position, -1 when nothing is set
    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [22:0] pack(input int idx, input logic w, input logic s);
        logic [15:0] o;
        logic [3:0]  p;
        o = '0;
        p = '0;
        if (idx >= 0) begin
            o = 16'(1) << idx;
            p = idx[3:0];
        end
        return {o, p, (idx >= 0) ? 1'b1 : 1'b0, w, s};
    endfunction

    task automatic model(input int k, input int ow, input bit wr, output logic [22:0] e);
        logic w, s;
        w = 1'b0;
        s = 1'b0;
        if (rst) begin
            m_idx[k] = -1;
        end else if (en) begin
            case (mode)
                2'b00: m_idx[k] = -1;
                2'b01: m_idx[k] = int'(sel_v) % ow;
                2'b10: if (m_idx[k] >= 0) begin
                    if (m_idx[k] < ow - 1) m_idx[k] = m_idx[k] + 1;
                    else if (wr) begin m_idx[k] = 0; w = 1'b1; end
                    else s = 1'b1;
                end
                default: if (m_idx[k] >= 0) begin
                    if (m_idx[k] > 0) m_idx[k] = m_idx[k] - 1;
                    else if (wr) begin m_idx[k] = ow - 1; w = 1'b1; end
                    else s = 1'b1;
                end
            endcase
        end
        e = pack(m_idx[k], w, s);
    endtask

    task automatic chk(input string tag, input logic [22:0] obs, input logic [22:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit e, input logic [1:0] m, input logic [5:0] s);
        logic [22:0] ex;
        rst = r; en = e; mode = m; sel_v = s;
        model(0, 8, 1'b1, ex);  exp_q3.push_back(ex);
        model(1, 8, 1'b0, ex);  exp_q3s.push_back(ex);
        model(2, 2, 1'b1, ex);  exp_q1.push_back(ex);
        model(3, 16, 1'b1, ex); exp_q4.push_back(ex);
        @(posedge clk);
        #1;
        chk("sb_u3",  {16'(o3),  4'(p3),  a3,  w3,  s3},  exp_q3.pop_front());
        chk("sb_u3s", {16'(o3s), 4'(p3s), a3s, w3s, s3s}, exp_q3s.pop_front());
        chk("sb_u1",  {16'(o1),  4'(p1),  a1,  w1,  s1},  exp_q1.pop_front());
        chk("sb_u4",  {16'(o4),  4'(p4),  a4,  w4,  s4},  exp_q4.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc1, wc4;
        logic [7:0] exp_oh;
        rst = 1'b1; en = 1'b0; mode = 2'b00; sel_v = '0;
        for (int k = 0; k < 4; k++) m_idx[k] = -1;
        #1;
        step(1, 1, 2'b01, 6'd4);
        step(1, 0, 2'b00, 6'd0);
        chk("rst_out", 23'(o3), 23'(0));
        chk("rst_flags", 23'({a3, w3, s3, p3}), 23'(0));

        // Load sweep
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 2'b01, 6'(i));
            exp_oh = 8'b1 << i;
            chk("load_out", 23'(o3), 23'(exp_oh));
            chk("load_pos", 23'(p3), 23'(i));
        end

        // Wrap / saturate at the top end
        step(0, 1, 2'b01, 6'd7);
        step(0, 1, 2'b10, 6'd0);
        chk("wrap_up_out", 23'(o3), 23'(8'b00000001));
        chk("wrap_up_pulse", 23'({w3, s3}), 23'(2'b10));
        chk("sat_up_out", 23'(o3s), 23'(8'b10000000));
        chk("sat_up_pulse", 23'({w3s, s3s}), 23'(2'b01));
        step(0, 1, 2'b10, 6'd0);
        chk("wrap_clear", 23'(w3), 23'(0));
        chk("sat_again", 23'({o3s, p3s, s3s}), 23'({8'b10000000, 3'd7, 1'b1}));
        step(0, 0, 2'b10, 6'd0);
        chk("sat_drop", 23'(s3s), 23'(0));

        // Wrap at the bottom end
        step(0, 1, 2'b01, 6'd0);
        step(0, 1, 2'b11, 6'd0);
        chk("wrap_dn", 23'({o3, p3, w3}), 23'({8'b10000000, 3'd7, 1'b1}));
        chk("sat_dn", 23'({o3s, p3s, s3s}), 23'({8'b00000001, 3'd0, 1'b1}));

        // Inactive shift and hold
        step(1, 0, 2'b00, 6'd0);
        step(0, 1, 2'b10, 6'd0);
        chk("inactive_shift", 23'({o3, a3, w3, s3}), 23'(0));
        step(0, 1, 2'b01, 6'd3);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 2'(i), 6'(i + 1));
            chk("hold_out", 23'(o3), 23'(8'b00001000));
        end

        // Reset wins over a simultaneous load
        step(0, 1, 2'b01, 6'd5);
        step(0, 1, 2'b10, 6'd0);
        step(1, 1, 2'b01, 6'd2);
        chk("rst_mid", 23'({o3, p3, a3, w3, s3}), 23'(0));
        step(0, 1, 2'b10, 6'd0);
        chk("rst_then_shift", 23'({o3, a3}), 23'(0));

        // Random commands, checked by the scoreboard
        for (int i = 0; i < 40; i++) begin
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), 6'($urandom_range(0, 15)));
        end

        // Parameter sweep: 2*OUT_W shift-ups from position 0
        step(0, 1, 2'b01, 6'd0);
        wc1 = 0;
        wc4 = 0;
        for (int i = 0; i < 32; i++) begin
            step(0, 1, 2'b10, 6'd0);
            if (i < 4) wc1 += int'(w1);
            wc4 += int'(w4);
        end
        chk("sweep_w1_wraps", 23'(wc1), 23'(2));
        chk("sweep_w4_wraps", 23'(wc4), 23'(2));
        chk("sweep_w4_pos", 23'(p4), 23'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/onehot_dec_seq.md
ONEHOT_DEC_SEQ -- requirements
Module: onehot_dec_seq

Interface
REQ-001 The block SHALL have parameter SEL_W, default 3, select/position width in bits (legal range 1..6).
REQ-002 The block SHALL have parameter WRAP, default 1, where 1 = shifts wrap around the ends and 0 = shifts saturate at the ends.
REQ-003 The block SHALL derive local constant OUT_W = 2**SEL_W, the one-hot output width.
REQ-004 The block SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-005 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port en  input  1  command strobe; 0 = hold all state.
REQ-007 The block SHALL have port mode  input  2  command: 00 clear, 01 load, 10 shift up, 11 shift down.
REQ-008 The block SHALL have port sel  input  SEL_W  load index, sampled only on load.
REQ-009 The block SHALL have port out  output  OUT_W  registered one-hot (or all-zero) decode.
REQ-010 The block SHALL have port pos  output  SEL_W  registered binary index of the set bit.
REQ-011 The block SHALL have port active  output  1  high when exactly one bit of out is set.
REQ-012 The block SHALL have port wrap  output  1  one-cycle pulse when a shift wraps an end.
REQ-013 The block SHALL have port sat  output  1  one-cycle pulse when a shift is blocked at an end (WRAP=0 only).

Function
REQ-014 All outputs SHALL be registered, with one-cycle latency from the command edge to the visible result.
REQ-015 The block SHALL maintain the invariant out == (active ? 1<<pos : 0) after every edge.
REQ-016 With en=0, out, pos and active SHALL hold, and wrap=sat=0.
REQ-017 On en=1 with mode=00, the block SHALL set out=0, pos=0 and active=0.
REQ-018 On en=1 with mode=01, the block SHALL set pos=sel, out=1<<sel and active=1, regardless of prior state.
REQ-019 On en=1 with mode=10 and active=1 and pos<OUT_W-1, the block SHALL set pos=pos+1 and rotate out left by 1.
REQ-020 On en=1 with mode=11 and active=1 and pos>0, the block SHALL set pos=pos-1 and rotate out right by 1.
REQ-021 On shift up at pos=OUT_W-1 with WRAP=1, the block SHALL set pos=0, set out=1 and pulse wrap=1.
REQ-022 On shift down at pos=0 with WRAP=1, the block SHALL set pos=OUT_W-1, set out=1<<(OUT_W-1) and pulse wrap=1.
REQ-023 On shift up at pos=OUT_W-1 or shift down at pos=0 with WRAP=0, the block SHALL hold pos and out and pulse sat=1.
REQ-024 A shift with active=0 SHALL be a no-op: out stays 0, pos stays 0, and wrap=sat=0.
REQ-025 wrap and sat SHALL be mutually exclusive, SHALL each be high for exactly one cycle per event, and SHALL be 0 on every other edge.
REQ-026 Position arithmetic SHALL be SEL_W-bit modulo, so no out-of-range pos can ever be produced.

Reset
REQ-027 With rst=1 at a rising edge, the block SHALL set out=0, pos=0, active=0, wrap=0 and sat=0.
REQ-028 rst SHALL take priority over en and mode, including a reset asserted mid-sequence.
REQ-029 The block SHALL act on the first command at the first edge with rst=0.
REQ-030 The block SHALL contain no asynchronous reset path, and rst SHALL have no effect between clock edges.

Verification (SEL_W=3 unless noted)
REQ-031 Load sweep: load sel=0..7 with en=1 -> on the next edge out=00000001..10000000, pos=sel and active=1 for each value.
REQ-032 Wrap: WRAP=1, load 7 then shift up -> out=00000001, pos=0 and wrap=1 for one cycle; load 0 then shift down -> out=10000000, pos=7 and wrap=1.
REQ-033 Saturate: WRAP=0, load 7 then shift up twice -> out=10000000 and pos=7 both times, with sat=1 for each blocked shift and wrap=0.
REQ-034 Inactive/hold: after reset, shift up -> out=0 and active=0; load 3 then en=0 for 4 cycles with mode toggling -> out=00001000 stays unchanged.
REQ-035 Reset mid-run: load 5, shift up, then assert rst in the same cycle as a load of 2 -> outputs are all 0 on the next edge; deassert rst and shift -> no change.
REQ-036 Parameter sweep: SEL_W=1 and SEL_W=4 with 2*OUT_W shift-up cycles -> pos increments modulo OUT_W, with exactly 2 wrap pulses.
